// File: rtl/pipe_ctrl_tracker_if.sv
// Pipeline control tracker bus: ID-stage inputs, stage-register views, counters.
// The master side drives ID fields and control requests; the slave side is the tracker.
interface pipe_ctrl_tracker_if;
  logic        id_valid, id_regwrite, id_memread, id_memwrite;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ctrlf, flush, halt_req, resume;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic        idex_memread, idex_valid;
  logic [4:0]  exmem_rd;
  logic        exmem_regwrite, exmem_memread, exmem_memwrite, exmem_valid;
  logic [4:0]  memwb_rd;
  logic        memwb_regwrite, memwb_valid;
  logic        id_accept, halted;
  logic [15:0] stall_count, flush_count;

  modport master (
    output id_valid, id_regwrite, id_memread, id_memwrite, id_rs1, id_rs2, id_rd,
           ctrlf, flush, halt_req, resume,
    input  idex_rs1, idex_rs2, idex_rd, idex_memread, idex_valid,
           exmem_rd, exmem_regwrite, exmem_memread, exmem_memwrite, exmem_valid,
           memwb_rd, memwb_regwrite, memwb_valid, id_accept, halted,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_regwrite, id_memread, id_memwrite, id_rs1, id_rs2, id_rd,
           ctrlf, flush, halt_req, resume,
    output idex_rs1, idex_rs2, idex_rd, idex_memread, idex_valid,
           exmem_rd, exmem_regwrite, exmem_memread, exmem_memwrite, exmem_valid,
           memwb_rd, memwb_regwrite, memwb_valid, id_accept, halted,
           stall_count, flush_count
  );
endinterface

// File: rtl/pipe_ctrl_tracker.sv
// Tracks ID/EX, EX/MEM, MEM/WB control fields, load-use/flush bubbles,
// a RUN/DRAIN/HALTED drain FSM and saturating stall/flush counters.
module pipe_ctrl_tracker (
  input logic               clk,
  input logic               reset,
  pipe_ctrl_tracker_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       regwrite, memread, memwrite, valid;
  } idex_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite, memread, memwrite, valid;
  } exmem_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite, valid;
  } memwb_t;

  state_t      state;
  idex_t       idex, idex_nxt;
  exmem_t      exmem;
  memwb_t      memwb;
  logic [15:0] stall_cnt, flush_cnt;
  logic        halted_q, accept, pipe_empty;

  assign accept     = bus.id_valid & (state == RUN) & ~bus.flush & ~bus.ctrlf;
  assign pipe_empty = ~idex.valid & ~exmem.valid & ~memwb.valid;

  // x0 is never a forwarding source, so its regwrite is dropped at capture
  always_comb begin
    idex_nxt = '0;
    if (accept) begin
      idex_nxt.rs1      = bus.id_rs1;
      idex_nxt.rs2      = bus.id_rs2;
      idex_nxt.rd       = bus.id_rd;
      idex_nxt.regwrite = bus.id_regwrite & (bus.id_rd != 5'd0);
      idex_nxt.memread  = bus.id_memread;
      idex_nxt.memwrite = bus.id_memwrite;
      idex_nxt.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      idex  <= idex_nxt;
      exmem <= '{rd: idex.rd, regwrite: idex.regwrite, memread: idex.memread,
                 memwrite: idex.memwrite, valid: idex.valid};
      memwb <= '{rd: exmem.rd, regwrite: exmem.regwrite, valid: exmem.valid};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state)
        RUN:    if (bus.halt_req) state <= DRAIN;
        DRAIN:  if (pipe_empty) begin
                  state    <= HALTED;
                  halted_q <= 1'b1;
                end
        HALTED: if (bus.resume) begin
                  state    <= RUN;
                  halted_q <= 1'b0;
                end
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // flush outranks ctrlf, so a simultaneous request counts only as a flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.ctrlf && !bus.flush && state == RUN && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (bus.flush && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.id_accept      = accept;
  assign bus.idex_rs1       = idex.rs1;
  assign bus.idex_rs2       = idex.rs2;
  assign bus.idex_rd        = idex.rd;
  assign bus.idex_memread   = idex.memread;
  assign bus.idex_valid     = idex.valid;
  assign bus.exmem_rd       = exmem.rd;
  assign bus.exmem_regwrite = exmem.regwrite;
  assign bus.exmem_memread  = exmem.memread;
  assign bus.exmem_memwrite = exmem.memwrite;
  assign bus.exmem_valid    = exmem.valid;
  assign bus.memwb_rd       = memwb.rd;
  assign bus.memwb_regwrite = memwb.regwrite;
  assign bus.memwb_valid    = memwb.valid;
  assign bus.halted         = halted_q;
  assign bus.stall_count    = stall_cnt;
  assign bus.flush_count    = flush_cnt;
endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// Directed + randomized bench for pipe_ctrl_tracker against a cycle-history model.
module tb_pipe_ctrl_tracker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_tracker_if bus();
  pipe_ctrl_tracker dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, mw, v;
  } rec_t;

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  // m[k] = what was accepted k+1 edges ago (bubble if nothing)
  rec_t m [3];
  int   mst, scnt, fcnt;
  int   nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m[i] = '0;
    mst = M_RUN; scnt = 0; fcnt = 0;
  endtask

  task automatic check_all();
    chk("idex_rs1", bus.idex_rs1, m[0].rs1);
    chk("idex_rs2", bus.idex_rs2, m[0].rs2);
    chk("idex_rd", bus.idex_rd, m[0].rd);
    chk("idex_memread", bus.idex_memread, m[0].mr);
    chk("idex_valid", bus.idex_valid, m[0].v);
    chk("exmem_rd", bus.exmem_rd, m[1].rd);
    chk("exmem_regwrite", bus.exmem_regwrite, m[1].rw);
    chk("exmem_memread", bus.exmem_memread, m[1].mr);
    chk("exmem_memwrite", bus.exmem_memwrite, m[1].mw);
    chk("exmem_valid", bus.exmem_valid, m[1].v);
    chk("memwb_rd", bus.memwb_rd, m[2].rd);
    chk("memwb_regwrite", bus.memwb_regwrite, m[2].rw);
    chk("memwb_valid", bus.memwb_valid, m[2].v);
    chk("halted", bus.halted, (mst == M_HALT) ? 1 : 0);
    chk("stall_count", bus.stall_count, scnt);
    chk("flush_count", bus.flush_count, fcnt);
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.ctrlf = 0; bus.flush = 0; bus.halt_req = 0; bus.resume = 0;
  endtask

  task automatic instr(input logic [4:0] rs1, rs2, rd, input logic rw, mr, mw);
    bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_regwrite = rw; bus.id_memread = mr; bus.id_memwrite = mw;
  endtask

  // Called shortly after a posedge with inputs already driven.
  task automatic step(input bit do_chk);
    bit   acc, empty;
    rec_t nr;
    int   nst;
    #1;
    acc = bus.id_valid && mst == M_RUN && !bus.flush && !bus.ctrlf;
    if (do_chk) chk("id_accept", bus.id_accept, acc);
    nr = '0;
    if (acc) begin
      nr.rs1 = bus.id_rs1; nr.rs2 = bus.id_rs2; nr.rd = bus.id_rd;
      nr.rw = bus.id_regwrite && bus.id_rd != 0;
      nr.mr = bus.id_memread; nr.mw = bus.id_memwrite; nr.v = 1;
    end
    empty = !m[0].v && !m[1].v && !m[2].v;
    nst = mst;
    if (mst == M_RUN && bus.halt_req) nst = M_DRAIN;
    else if (mst == M_DRAIN && empty) nst = M_HALT;
    else if (mst == M_HALT && bus.resume) nst = M_RUN;
    if (bus.ctrlf && !bus.flush && mst == M_RUN && scnt < 65535) scnt++;
    if (bus.flush && fcnt < 65535) fcnt++;
    @(posedge clk);
    m[2] = m[1]; m[1] = m[0]; m[0] = nr; mst = nst;
    #1;
    if (do_chk) check_all();
  endtask

  initial begin
    idle();
    model_reset();
    // reset asserted from time 0: outputs must already be clear
    #1;
    check_all();
    chk("rst_id_accept_idle", bus.id_accept, 0);
    // no capture on an edge where reset is still high
    instr(1, 2, 3, 1, 0, 0);
    @(posedge clk); #1;
    chk("rst_edge_no_capture", bus.idex_valid, 0);
    check_all();
    reset = 0;

    // single instruction walks down the pipe
    instr(1, 2, 5, 1, 0, 0);
    step(1); chk("s_idex_rd", bus.idex_rd, 5);
    idle();
    step(1); chk("s_exmem_rd", bus.exmem_rd, 5); chk("s_exmem_rw", bus.exmem_regwrite, 1);
    step(1); chk("s_memwb_rd", bus.memwb_rd, 5);

    // load-use bubble
    instr(3, 4, 7, 1, 0, 0); bus.ctrlf = 1;
    #1 chk("lu_accept", bus.id_accept, 0);
    step(1);
    chk("lu_idex_valid", bus.idex_valid, 0); chk("lu_idex_rd", bus.idex_rd, 0);
    chk("lu_stall", bus.stall_count, 1);

    // flush beats ctrlf
    bus.flush = 1;
    step(1);
    chk("fp_flush", bus.flush_count, 1); chk("fp_stall", bus.stall_count, 1);
    chk("fp_idex_valid", bus.idex_valid, 0);

    // rd=0 never writes
    idle(); instr(0, 0, 0, 1, 1, 0);
    step(1); idle(); step(1);
    chk("x0_exmem_rw", bus.exmem_regwrite, 0); chk("x0_exmem_valid", bus.exmem_valid, 1);

    // drain: halt pulsed at edge N with a full pipe
    for (int i = 0; i < 3; i++) begin instr(5'(i + 1), 0, 5'(i + 10), 1, 1, 1); step(1); end
    instr(9, 9, 9, 1, 0, 0); bus.halt_req = 1;
    step(1);
    chk("dr_n_captured", bus.idex_valid, 1);
    idle();
    for (int i = 1; i <= 3; i++) begin step(1); chk("dr_not_halted", bus.halted, 0); end
    chk("dr_empty", {bus.idex_valid, bus.exmem_valid, bus.memwb_valid}, 0);
    instr(1, 1, 1, 1, 0, 0);
    step(1); chk("dr_halted", bus.halted, 1); chk("dr_no_capture", bus.idex_valid, 0);
    bus.halt_req = 1;
    step(1); chk("hl_ignore_halt", bus.halted, 1);
    bus.halt_req = 0; bus.resume = 1;
    step(1); chk("rs_running", bus.halted, 0);
    bus.resume = 0;
    step(1); chk("rs_capture", bus.idex_valid, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      bus.id_valid = ($urandom_range(0, 3) != 0);
      bus.id_regwrite = 1'($urandom); bus.id_memread = 1'($urandom);
      bus.id_memwrite = 1'($urandom);
      bus.id_rs1 = 5'($urandom); bus.id_rs2 = 5'($urandom);
      bus.id_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.ctrlf = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.halt_req = ($urandom_range(0, 29) == 0);
      bus.resume = ($urandom_range(0, 4) == 0);
      step(1);
    end

    // saturation from a fresh reset
    idle();
    #1 reset = 1; #1 reset = 0; model_reset();
    @(posedge clk); #1;
    bus.ctrlf = 1;
    for (int i = 0; i < 65535; i++) step(0);
    check_all();
    chk("sat_preset", bus.stall_count, 16'hFFFF);
    step(1);
    chk("sat_hold", bus.stall_count, 16'hFFFF);

    // async reset mid-drain with all stages valid
    idle();
    for (int i = 0; i < 3; i++) begin instr(5'(i + 4), 5'(i + 5), 5'(i + 6), 1, 1, 1); step(1); end
    instr(2, 3, 4, 1, 0, 1); bus.halt_req = 1;
    step(1);
    chk("ar_full", {bus.idex_valid, bus.exmem_valid, bus.memwb_valid}, 3'b111);
    idle(); bus.id_valid = 1;
    #1 chk("ar_draining", bus.id_accept, 0);
    reset = 1; model_reset();
    #1;
    check_all();
    chk("ar_run_accept", bus.id_accept, 1);
    idle();
    @(posedge clk); #1;
    reset = 0;
    instr(1, 2, 3, 1, 0, 0);
    step(1); chk("ar_restart", bus.idex_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
